// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and helpers for the instruction sequencer:
//   opcode_e - top two instruction bits (register ops / load-immediate)
//   func_e   - low four instruction bits, doubles as the ALU operation code
//   state_e  - sequencer timestep; its encoding is the `step` output value
//   is_binary / is_unary - classify a func code as a 3- or 2-step ALU op
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam int OPC_W  = 2;
  localparam int FUNC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_REG  = 2'b00,
    OP_LDI  = 2'b01,
    OP_RSV2 = 2'b10,
    OP_RSV3 = 2'b11
  } opcode_e;

  typedef enum logic [FUNC_W-1:0] {
    LOAD = 4'b0000,
    COPY = 4'b0001,
    ADD  = 4'b0010,
    SUB  = 4'b0011,
    NOT  = 4'b0100,
    NEG  = 4'b0101,
    AND  = 4'b0110,
    OR   = 4'b0111,
    XOR  = 4'b1000,
    LSL  = 4'b1001,
    LSR  = 4'b1010,
    ASR  = 4'b1011
  } func_e;

  // Encoding equals the timestep number reported on `step`.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_T1    = 2'd1,
    S_T2    = 2'd2,
    S_T3    = 2'd3
  } state_e;

  // RX <- RX op RY: ADD, SUB and AND..ASR.
  function automatic logic is_binary(input logic [FUNC_W-1:0] f);
    return (f == ADD) || (f == SUB) || ((f >= AND) && (f <= ASR));
  endfunction

  // RX <- f(RY): NOT, NEG.
  function automatic logic is_unary(input logic [FUNC_W-1:0] f);
    return (f == NOT) || (f == NEG);
  endfunction

endpackage

// File: rtl/ir_decode.sv
// ---------------------------------------------------------------------------
// ir_decode
// Purely combinational split of the instruction register into its fields and
// instruction-class flags.
// Ports:
//   ir       in  DATA_W  instruction register contents
//   opcode   out 2       IR[DATA_W-1:DATA_W-2]
//   rx, ry   out REG_W   X and Y register fields
//   func     out 4       IR[3:0]
//   imm      out DATA_W  IR[DATA_W-3-REG_W:0] sign-extended
//   is_bin, is_un, is_copy, is_load, is_ldi, is_ill  out 1  class flags
// ---------------------------------------------------------------------------
module ir_decode
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int REG_W  = 2
) (
  input  logic [DATA_W-1:0] ir,
  output logic [OPC_W-1:0]  opcode,
  output logic [REG_W-1:0]  rx,
  output logic [REG_W-1:0]  ry,
  output logic [FUNC_W-1:0] func,
  output logic [DATA_W-1:0] imm,
  output logic              is_bin,
  output logic              is_un,
  output logic              is_copy,
  output logic              is_load,
  output logic              is_ldi,
  output logic              is_ill
);

  // The immediate occupies everything below the X field (Y and func included).
  localparam int IMM_W = DATA_W - OPC_W - REG_W;

  logic is_reg;

  assign opcode = ir[DATA_W-1 -: OPC_W];
  assign rx     = ir[DATA_W-OPC_W-1 -: REG_W];
  assign ry     = ir[DATA_W-OPC_W-REG_W-1 -: REG_W];
  assign func   = ir[FUNC_W-1:0];
  assign imm    = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

  assign is_reg  = (opcode == OP_REG);
  assign is_ldi  = (opcode == OP_LDI);
  assign is_load = is_reg && (func == LOAD);
  assign is_copy = is_reg && (func == COPY);
  assign is_un   = is_reg && is_unary(func);
  assign is_bin  = is_reg && is_binary(func);
  // Opcodes 10/11 and register ops with func 1100-1111 fall through here.
  assign is_ill  = !(is_ldi || is_load || is_copy || is_un || is_bin);

endmodule

// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
// Clocked instruction controller: fetches a word from the external bus with a
// valid/ready handshake into IR, then sequences it over 1-3 further timesteps,
// driving register-file and ALU enables combinationally from state and IR.
// Requires DATA_W >= 6 + 2*REG_W and NREG a power of two >= 2.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   run                   permits new fetches (only looked at in FETCH)
//   instr_in/instr_valid  external bus word and its valid
//   instr_ready           bus word accepted this cycle (with instr_valid)
//   IMM, ImmOut           sign-extended immediate and its bus drive
//   Rin/ENW, Rout/ENR     register write / read address and enable
//   Ain, Gin, Gout        ALU operand latch, result latch, result drive
//   ALUcont               ALU operation (func field)
//   Ext                   drive external data onto the bus
//   IRin                  instruction latched this cycle
//   done, illegal         final-cycle pulse, undefined-encoding pulse
//   busy, step            not in FETCH, current timestep 0-3
// ---------------------------------------------------------------------------
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter  int DATA_W = 10,
  parameter  int NREG   = 4,
  localparam int REG_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] IMM,
  output logic              ImmOut,
  output logic [REG_W-1:0]  Rin,
  output logic [REG_W-1:0]  Rout,
  output logic              ENW,
  output logic              ENR,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic [3:0]        ALUcont,
  output logic              Ext,
  output logic              IRin,
  output logic              done,
  output logic              illegal,
  output logic              busy,
  output logic [1:0]        step
);

  state_e            state;
  logic [DATA_W-1:0] ir;

  logic [OPC_W-1:0]  opcode;
  logic [REG_W-1:0]  rx;
  logic [REG_W-1:0]  ry;
  logic [FUNC_W-1:0] func;
  logic [DATA_W-1:0] imm;
  logic              is_bin;
  logic              is_un;
  logic              is_copy;
  logic              is_load;
  logic              is_ldi;
  logic              is_ill;

  ir_decode #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_ir_decode (
    .ir      (ir),
    .opcode  (opcode),
    .rx      (rx),
    .ry      (ry),
    .func    (func),
    .imm     (imm),
    .is_bin  (is_bin),
    .is_un   (is_un),
    .is_copy (is_copy),
    .is_load (is_load),
    .is_ldi  (is_ldi),
    .is_ill  (is_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (run && instr_valid) begin
            ir    <= instr_in;
            state <= S_T1;
          end
        end
        S_T1: begin
          if (is_ldi || is_copy || is_ill) begin
            state <= S_FETCH;
          end else if (is_load) begin
            // Load stalls in T1 until its data word is handshaken.
            if (instr_valid) begin
              state <= S_FETCH;
            end
          end else begin
            state <= S_T2;
          end
        end
        S_T2:    state <= is_bin ? S_T3 : S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    instr_ready = 1'b0;
    Ext         = 1'b0;
    IRin        = 1'b0;
    IMM         = '0;
    ImmOut      = 1'b0;
    Rin         = '0;
    Rout        = '0;
    ENW         = 1'b0;
    ENR         = 1'b0;
    Ain         = 1'b0;
    Gin         = 1'b0;
    Gout        = 1'b0;
    ALUcont     = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        instr_ready = run;
        Ext         = run;
        // No latch can happen while reset is held, so don't advertise one.
        IRin        = run && instr_valid && rst_n;
      end
      S_T1: begin
        if (is_ill) begin
          illegal = 1'b1;
          done    = 1'b1;
        end else if (opcode == OP_LDI) begin
          IMM    = imm;
          ImmOut = 1'b1;
          ENW    = 1'b1;
          Rin    = rx;
          done   = 1'b1;
        end else if (is_load) begin
          instr_ready = 1'b1;
          Ext         = 1'b1;
          if (instr_valid) begin
            ENW  = 1'b1;
            Rin  = rx;
            done = 1'b1;
          end
        end else if (is_copy) begin
          ENR  = 1'b1;
          Rout = ry;
          ENW  = 1'b1;
          Rin  = rx;
          done = 1'b1;
        end else if (is_un) begin
          ENR     = 1'b1;
          Rout    = ry;
          Gin     = 1'b1;
          ALUcont = func;
        end else begin
          // Binary op: first operand RX goes to the A latch.
          ENR  = 1'b1;
          Rout = rx;
          Ain  = 1'b1;
        end
      end
      S_T2: begin
        if (is_un) begin
          Gout = 1'b1;
          ENW  = 1'b1;
          Rin  = rx;
          done = 1'b1;
        end else begin
          ENR     = 1'b1;
          Rout    = ry;
          Gin     = 1'b1;
          ALUcont = func;
        end
      end
      S_T3: begin
        Gout = 1'b1;
        ENW  = 1'b1;
        Rin  = rx;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_FETCH);
  assign step = state;

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised, clocked successor to the processor's combinational instruction controller. It absorbs the external timestep counter and the instruction register, so it can run any register count and data width. It fetches instructions from the external bus with a valid/ready handshake and sequences them over 2–4 timesteps. It adds a sign-extended load-immediate, illegal-instruction detection, and `done`/`busy` status. It sits between the external input bus and the register file / ALU datapath, and drives their enables directly.

## Interface
Parameters:
- `DATA_W`, default 10: instruction and data word width; must satisfy DATA_W ≥ 6 + 2·REG_W.
- `NREG`, default 4: register-file depth; must be a power of two, ≥ 2.
- `REG_W`, default $clog2(NREG): register address width; derived, not overridden.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `run`  in  1: permits new fetches.
- `instr_in`  in  DATA_W: external bus word (instruction or load data).
- `instr_valid`  in  1: `instr_in` is valid.
- `instr_ready`  out  1: controller accepts `instr_in` this cycle.
- `IMM`  out  DATA_W: sign-extended immediate.
- `ImmOut`  out  1: drive `IMM` onto the bus.
- `Rin`  out  REG_W: register write address.
- `Rout`  out  REG_W: register read address.
- `ENW`  out  1: register-file write enable.
- `ENR`  out  1: register-file read enable.
- `Ain`  out  1: latch ALU A operand.
- `Gin`  out  1: latch ALU result G.
- `Gout`  out  1: drive G onto the bus.
- `ALUcont`  out  4: ALU operation.
- `Ext`  out  1: drive external data onto the bus.
- `IRin`  out  1: instruction latched this cycle.
- `done`  out  1: one-cycle pulse in an instruction's final cycle.
- `illegal`  out  1: one-cycle pulse on an undefined encoding.
- `busy`  out  1: high while the controller is in any state other than FETCH.
- `step`  out  2: current timestep, 0–3.

## Operation
- Instruction fields, MSB first:
  - opcode: 2 bits.
  - X: REG_W bits.
  - Y: REG_W bits.
  - func: low 4 bits.
  - imm: IR[DATA_W-3-REG_W:0], sign-extended to DATA_W to form `IMM`.
- States are FETCH(T0), T1, T2, T3.
- FETCH:
  - `instr_ready` = `run`; `Ext` = `run`.
  - On the valid&ready handshake: IR ← `instr_in`, `IRin`=1, go to T1.
  - With no handshake, stay in FETCH.
- Opcode 01 (load immediate):
  - T1: `ImmOut`, `ENW`, `Rin`=X, `done`; go to FETCH.
- Opcode 00, func 0000 (load):
  - T1: `instr_ready`=1, `Ext`=1.
  - On handshake: `ENW`, `Rin`=X, `done`, go to FETCH.
  - Otherwise stall in T1 with `ENW`=0.
- Opcode 00, func 0001 (copy):
  - T1: `ENR`, `Rout`=Y, `ENW`, `Rin`=X, `done`.
- Opcode 00, func 0100 / 0101 (unary, RX ← f(RY)):
  - T1: `ENR`, `Rout`=Y, `Gin`, `ALUcont`=func.
  - T2: `Gout`, `ENW`, `Rin`=X, `done`.
- Opcode 00, func 0010, 0011, 0110–1011 (binary, RX ← RX op RY):
  - T1: `ENR`, `Rout`=X, `Ain`.
  - T2: `ENR`, `Rout`=Y, `Gin`, `ALUcont`=func.
  - T3: `Gout`, `ENW`, `Rin`=X, `done`.
- Illegal encodings are opcode 10, opcode 11, and opcode 00 with func 1100–1111.
  - T1: `illegal`=1, `done`=1, no enables; go to FETCH.
- Every output not listed for a state is 0, including `Rin`, `Rout`, `ALUcont`, `IMM` (IMM is 0 unless opcode 01).

## Timing
- On reset assertion, asynchronously:
  - state = FETCH and IR = 0.
  - Every output is 0, except `instr_ready` and `Ext`, which follow `run`.
- Reset mid-instruction aborts it; no partial write occurs after reset asserts.
- Outputs are decoded combinationally from state and IR; `instr_ready` also depends on `run`.
- Latency from fetch handshake to `done`:
  - load imm and copy: 1 cycle;
  - load: 1 + stall cycles;
  - unary: 2 cycles;
  - binary: 3 cycles.
- Back-to-back throughput: FETCH is the cycle after `done`, so a binary op occupies 4 cycles minimum.
- `run` is sampled only in FETCH. Deasserting it mid-instruction lets the instruction complete, then the controller idles in FETCH.
- `step` is 0 in FETCH, 1/2/3 in T1/T2/T3; it never exceeds 3.
- `instr_valid` without `instr_ready` is ignored, and `instr_in` is not latched.

## Structure
- `ctrl_pkg` contains:
  - opcode enum: OP_REG=00, OP_LDI=01;
  - func/ALU enum: LOAD=0000 … ASR=1011;
  - state enum;
  - helper function `is_binary(func)`.
- One combinational sub-module, `ir_decode`: splits IR into opcode/X/Y/func/IMM and produces the class flags (binary, unary, copy, load, ldi, illegal).
- The FSM and IR register live in `ctrl_sequencer`.

## Test plan
- Default parameters, fetch 0x026 (AND R0,R2), then run to completion:
  - T1: `Rout`=0, `Ain`;
  - T2: `Rout`=2, `Gin`, `ALUcont`=0110;
  - T3: `Rin`=0, `ENW`, `Gout`, `done`;
  - the following cycle: `busy`=0.
- Fetch 0x17F (LDI R1,-1): T1 gives `IMM`=0x3FF, `ImmOut`, `ENW`, `Rin`=1, `done`.
- Fetch 0x0C0 (load R3), hold `instr_valid` low 3 cycles, then present 0x155:
  - T1 holds with `ENW`=0 during the stall;
  - handshake cycle: `ENW`, `Rin`=3, `Ext`, `done`.
- Fetch 0x20F (opcode 10) and 0x00C (func 1100): each gives a 1-cycle `illegal`+`done`, no `ENW`, and a return to FETCH.
- `rst_n` low in T2 of an ADD:
  - all enables drop the same cycle;
  - after release: `step`=0 and no `ENW` until a new fetch.
- DATA_W=16, NREG=8, fetch XOR R5,R6 with `run` dropped in T1:
  - `Rout`=5 then 6, `Rin`=5, `ALUcont`=1000;
  - then the controller idles in FETCH with `instr_ready`=0.
